full_adder8: RTL and testbench

Registered 8-bit binary adder for the EMU v8-1 datapath. It adds two unsigned 8-bit operands and a carry-in, producing an 8-bit sum and carry-out, plus signed-overflow and zero flags for the ALU status logic. The combinational core is a ripple chain of eight 1-bit full adders, each built from two half adders and an OR gate. All outputs are registered on a single clock.

---
 rtl/full_adder8.sv | 71 +++++++
 tb/tb_full_adder8.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder8.sv
// Registered 8-bit ripple-carry adder with carry, signed-overflow and zero flags.
// The combinational core is eight 1-bit full adders, each made of two half adders.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module full_adder8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       ovf,
  output logic       zero
);
  logic [8:0] c;
  logic [7:0] sum;

  assign c[0] = cin;

  // Carry ripples from bit 0 to bit 7; c[8] is the carry out of the MSB.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    full_adder1 u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (sum[i]),
      .co(c[i+1])
    );
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 8'h00;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      s    <= sum;
      cout <= c[8];
      ovf  <= c[7] ^ c[8];
      zero <= (sum == 8'h00);
    end
  end
endmodule

// File: tb/tb_full_adder8.sv
// Self-checking bench for full_adder8: directed corner cases plus a
// back-to-back random run scored against an arithmetic reference model.

module tb_full_adder8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] s;
  logic       cout, ovf, zero;

  int checks   = 0;
  int failures = 0;

  full_adder8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference packed as {cout, s[7:0], ovf, zero}, derived from plain arithmetic.
  function automatic logic [10:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rc);
    int unsigned total;
    int          sa, sb, ssum;
    logic        r_ovf;
    total = int'(ra) + int'(rb) + int'(rc);
    sa    = ra[7] ? int'(ra) - 256 : int'(ra);
    sb    = rb[7] ? int'(rb) - 256 : int'(rb);
    ssum  = sa + sb + int'(rc);
    r_ovf = (ssum > 127) || (ssum < -128);
    return {total[8], total[7:0], r_ovf, total[7:0] == 0};
  endfunction

  function automatic logic [10:0] observed();
    return {cout, s, ovf, zero};
  endfunction

  // Drive one operand set, let one edge capture it, and compare just after that edge.
  task automatic apply_and_check(input string name, input logic [7:0] ta,
                                 input logic [7:0] tb, input logic tc);
    logic [10:0] exp;
    @(negedge clk);
    a = ta; b = tb; cin = tc;
    exp = ref_model(ta, tb, tc);
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL %s: a=%0d b=%0d cin=%0d got {cout,s,ovf,zero}=%b_%h_%b_%b want %b_%h_%b_%b",
               name, ta, tb, tc, cout, s, ovf, zero, exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    #1;
    checks++;
    if (observed() !== 11'b0) begin
      failures++;
      $display("FAIL reset_initial: got %b want 0", observed());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== 11'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b want 0", i, observed());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release loads the inputs held during reset.
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== ref_model(8'hFF, 8'hFF, 1'b1)) begin
      failures++;
      $display("FAIL reset_release: got %b want %b", observed(), ref_model(8'hFF, 8'hFF, 1'b1));
    end
  endtask

  task automatic test_basic();
    apply_and_check("basic_10_15", 8'd10, 8'd15, 1'b0);
    checks++;
    if (s !== 8'b0001_1001) begin
      failures++;
      $display("FAIL basic_literal: got s=%h want 19", s);
    end
  endtask

  task automatic test_wrap();
    apply_and_check("wrap_255_1", 8'd255, 8'd1, 1'b0);
    apply_and_check("wrap_1_255", 8'd1, 8'd255, 1'b0);
    checks++;
    if ({cout, zero, ovf, s} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL wrap_literal: got cout=%b zero=%b ovf=%b s=%h want 1 1 0 00",
               cout, zero, ovf, s);
    end
  endtask

  task automatic test_carry_in();
    apply_and_check("max_255_255_1", 8'd255, 8'd255, 1'b1);
    apply_and_check("cin_only", 8'd0, 8'd0, 1'b1);
    apply_and_check("all_zero", 8'd0, 8'd0, 1'b0);
  endtask

  task automatic test_overflow();
    apply_and_check("ovf_127_1", 8'd127, 8'd1, 1'b0);
    checks++;
    if ({s, ovf, cout} !== {8'd128, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ovf_literal: got s=%0d ovf=%b cout=%b want 128 1 0", s, ovf, cout);
    end
    apply_and_check("ovf_128_128", 8'd128, 8'd128, 1'b0);
    apply_and_check("neg_no_ovf", 8'd128, 8'd127, 1'b1);
    apply_and_check("ovf_pos_cin", 8'd64, 8'd63, 1'b1);
  endtask

  task automatic test_async_reset();
    apply_and_check("pre_async", 8'd100, 8'd50, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 11'b0) begin
      failures++;
      $display("FAIL async_reset: got %b want 0 without a clock edge", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd200; b = 8'd100; cin = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== ref_model(8'd200, 8'd100, 1'b0)) begin
      failures++;
      $display("FAIL async_release: got %b want %b", observed(), ref_model(8'd200, 8'd100, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] pending[$];
    logic [10:0] exp;
    logic [7:0]  ra, rb;
    logic        rc;
    int          bad = 0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (pending.size() != 0) begin
        exp = pending.pop_front();
        checks++;
        if (observed() !== exp) begin
          failures++;
          bad++;
          if (bad <= 10)
            $display("FAIL back_to_back #%0d: got %b want %b", i, observed(), exp);
        end
      end
      if (i < 1000) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        pending.push_back(ref_model(ra, rb, rc));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_carry_in();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
